// File: rtl/regfile_access_pkg.sv
// Shared types for the register-file access master: bus widths, request
// payload and sequencer states.
package regfile_access_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;

  // One queued access: write flag plus both port addresses and write data.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] wdata1;
    logic [DATA_W-1:0] wdata2;
  } req_t;

  localparam int unsigned REQ_W = $bits(req_t);

  // Access sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    WRITE  = 3'd2,
    SETTLE = 3'd3,
    RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/regfile_access_master_req_fifo.sv
// Request queue for regfile_access_master: DEPTH-entry synchronous FIFO of
// request structs. The registered ready flag is the !full view used as the
// upstream req_ready; the head entry is presented combinationally.
module req_fifo
  import regfile_access_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  req_t push_data,
  input  logic pop,
  output req_t pop_data_c,
  output logic full_c,
  output logic empty_c,
  output logic ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  req_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign full_c     = (count == CNT_W'(DEPTH));
  assign empty_c    = (count == '0);
  assign do_push    = push && !full_c;
  assign do_pop     = pop && !empty_c;
  assign pop_data_c = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
  end

  // Pointers, occupancy and registered ready (low during reset and when full).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      ready <= (count_d != CNT_W'(DEPTH));
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/regfile_access_master.sv
// Initiator for the dual-port register file: queues requests, sequences
// address setup, write-enable pulse and read settle, then returns both read
// ports (post-write readback for writes) on a valid/ready response channel.
// Optional feature macro: WR_COLLIDE_CHECK_EN rejects writes whose two port
// addresses match (no write pulse, readback still done, rsp_err=1).
module regfile_access_master
  import regfile_access_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WR_PULSE   = 1,
  parameter int unsigned RD_WAIT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic [DATA_W-1:0] req_wdata1,
  input  logic [DATA_W-1:0] req_wdata2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata1,
  output logic [DATA_W-1:0] rsp_rdata2,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] rf_addr1,
  output logic [ADDR_W-1:0] rf_addr2,
  output logic [DATA_W-1:0] rf_wdata1,
  output logic [DATA_W-1:0] rf_wdata2,
  output logic              rf_w_en,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2
);

  localparam int unsigned CNT_MAX = (WR_PULSE > RD_WAIT) ? WR_PULSE : RD_WAIT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              wr_q;
  logic              wr_d;
  logic [ADDR_W-1:0] addr1_d;
  logic [ADDR_W-1:0] addr2_d;
  logic [DATA_W-1:0] wdata1_d;
  logic [DATA_W-1:0] wdata2_d;
  logic              w_en_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rdata1_d;
  logic [DATA_W-1:0] rdata2_d;
  logic              err_d;

  req_t              push_data;
  req_t              head_c;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full_c;
  logic              fifo_empty_c;

  assign push_data = '{wr:     req_wr,
                       addr1:  req_addr1,
                       addr2:  req_addr2,
                       wdata1: req_wdata1,
                       wdata2: req_wdata2};
  assign fifo_push = req_valid && req_ready && !fifo_full_c;

  req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_data  (push_data),
    .pop        (fifo_pop),
    .pop_data_c (head_c),
    .full_c     (fifo_full_c),
    .empty_c    (fifo_empty_c),
    .ready      (req_ready)
  );

  // Sequencer next state plus next values of every registered output.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr1_d     = rf_addr1;
    addr2_d     = rf_addr2;
    wdata1_d    = rf_wdata1;
    wdata2_d    = rf_wdata2;
    w_en_d      = 1'b0;
    rsp_valid_d = rsp_valid;
    rdata1_d    = rsp_rdata1;
    rdata2_d    = rsp_rdata2;
    err_d       = rsp_err;
    fifo_pop    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty_c) begin
          fifo_pop = 1'b1;
          wr_d     = head_c.wr;
          addr1_d  = head_c.addr1;
          addr2_d  = head_c.addr2;
          wdata1_d = head_c.wdata1;
          wdata2_d = head_c.wdata2;
          err_d    = 1'b0;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        cnt_d = '0;
        if (wr_q) begin
`ifdef WR_COLLIDE_CHECK_EN
          if (rf_addr1 == rf_addr2) begin
            err_d   = 1'b1;
            state_d = SETTLE;
          end else begin
            w_en_d  = 1'b1;
            state_d = WRITE;
          end
`else
          w_en_d  = 1'b1;
          state_d = WRITE;
`endif
        end else begin
          state_d = SETTLE;
        end
      end

      WRITE: begin
        if (cnt_q == CNT_W'(WR_PULSE - 1)) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          w_en_d = 1'b1;
        end
      end

      SETTLE: begin
        if (cnt_q == CNT_W'(RD_WAIT - 1)) begin
          cnt_d       = '0;
          rdata1_d    = rf_rdata1;
          rdata2_d    = rf_rdata2;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything, dropping rf_w_en at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      rf_addr1   <= '0;
      rf_addr2   <= '0;
      rf_wdata1  <= '0;
      rf_wdata2  <= '0;
      rf_w_en    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata1 <= '0;
      rsp_rdata2 <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rf_addr1   <= addr1_d;
      rf_addr2   <= addr2_d;
      rf_wdata1  <= wdata1_d;
      rf_wdata2  <= wdata2_d;
      rf_w_en    <= w_en_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata1 <= rdata1_d;
      rsp_rdata2 <= rdata2_d;
      rsp_err    <= err_d;
    end
  end

endmodule
